// File: rtl/mcu_misr.sv
// mcu_misr: multiple-input signature register for one MCU interface bus.
// After misr_reset, it compresses data_in over a fixed window of WINDOW
// clock cycles. It then freezes the signature and raises sig_valid so the
// MCU signature checker can compare it.
module mcu_misr #(
  parameter int unsigned             WIDTH  = 1614,
  parameter logic [WIDTH-1:0]        POLY   = WIDTH'(1),
  parameter int unsigned             WINDOW = 124,
  parameter int unsigned             CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             misr_reset,
  input  logic             ena,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] signature,
  output logic             sig_valid,
  output logic             busy,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Count value at the edge that performs the last compress of the window.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] WIN_CNT  = CNT_W'(WINDOW);

  state_e           state_q;
  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] sig_d;
  logic [CNT_W-1:0] cnt_q;
  logic             sig_valid_q;
  logic             busy_q;

  // Next signature value for one compress step: shift, feed back, and absorb data_in.
  always_comb begin
    // NOTE: always_comb outputs get an unconditional default first so no latch is inferred.
    sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ data_in;
    if (sig_q[WIDTH-1]) begin
      sig_d = sig_d ^ POLY;
    end
  end

  // Window FSM. The clear request outranks everything; all outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
      state_q     <= IDLE;
      sig_q       <= '0;
      cnt_q       <= '0;
      sig_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (misr_reset) begin
      state_q     <= RUN;
      sig_q       <= '0;
      cnt_q       <= '0;
      sig_valid_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          busy_q      <= 1'b0;
          sig_valid_q <= 1'b0;
        end
        RUN: begin
          if (ena) begin
            sig_q <= sig_d;
          end
          if (cnt_q == LAST_CNT) begin
            cnt_q       <= WIN_CNT;
            state_q     <= DONE;
            busy_q      <= 1'b0;
            sig_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          busy_q      <= 1'b0;
          sig_valid_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          sig_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign signature = sig_q;
  assign sig_valid = sig_valid_q;
  assign busy      = busy_q;
  assign cycle_cnt = cnt_q;

endmodule
